mem_arbiter: RTL
================

# mem_arbiter

Two-port memory arbiter that shares one single-port, fixed-latency data memory between the instruction-fetch port and the data (load/store) port of `proc`. It sits inside `proc`, between the fetch/memory stages and the memory model. It serialises accesses, enforces round-robin fairness under contention and flags misaligned word accesses. Each requester sees a request/done handshake; the memory sees one registered command per access.

## Interface
- `ADDR_W`, 16, address width in bits
- `DATA_W`, 16, data width in bits
- `LAT`, 4, memory read/write latency in cycles (≥1); read data is valid exactly `LAT` cycles after the command cycle
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_req`  in  1  fetch request (level); held until `i_done`
- `i_addr`  in  ADDR_W  fetch address, stable while `i_req` is high
- `i_rdata`  out  DATA_W  fetch data, valid while `i_done` is high
- `i_done`  out  1  one-cycle fetch completion pulse
- `d_req`  in  1  data request (level); held until `d_done`
- `d_wr`  in  1  1 = store, 0 = load; stable with `d_req`
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_rdata`  out  DATA_W  load data, valid while `d_done` is high; 0 on store completion
- `d_done`  out  1  one-cycle data completion pulse
- `err`  out  1  one-cycle misalignment flag, coincident with the corresponding done
- `mem_en`  out  1  one-cycle memory command strobe
- `mem_wr`  out  1  command is a write
- `mem_addr`  out  ADDR_W  command address
- `mem_wdata`  out  DATA_W  command write data
- `mem_rdata`  in  DATA_W  memory read data, valid `LAT` cycles after the `mem_en` cycle

## Operation
- FSM states and transitions:
  - IDLE: samples requests.
  - ISSUE: drives `mem_en` (registered).
  - WAIT: down-counter, `LAT` cycles.
  - RESP: drives done (registered).
  - IDLE→ISSUE on an aligned grant; ISSUE→WAIT (counter loaded `LAT-1`); WAIT→RESP when the counter is 0; RESP→IDLE unconditionally.
  - IDLE→RESP directly on a misaligned grant.
- Grant, in IDLE only:
  - One requester high: that requester wins.
  - Both high: the port not granted last wins.
  - `last` resets to I, so D wins the first contention.
  - Under continuous dual requests, grants alternate D, I, D, I.
- Grant latches port, address, `wr` and `wdata` into internal registers. Memory outputs come only from these registers, never combinationally from the request inputs.
- `mem_rdata` is captured in the final WAIT cycle (counter = 0).
- In RESP:
  - Only the granted port's done is high; `i_done` and `d_done` are never high together.
  - Rdata outputs show the captured value for reads and 0 for writes/errors.
- Misalignment: `addr[0]=1` on the granted port.
  - No `mem_en` is issued.
  - RESP drives done=1, `err`=1, rdata=0.
  - `last` is updated as for a normal grant.
- Requests are ignored in ISSUE, WAIT and RESP; a req still high in RESP is re-arbitrated in the following IDLE cycle.
- Dropping `req` before done is a protocol violation. The arbiter still completes the access and pulses done.
- Outputs when not asserted:
  - `mem_en`, `*_done` and `err` are 0.
  - `mem_wr`, `mem_addr` and `mem_wdata` are 0 outside ISSUE.
  - `i_rdata` and `d_rdata` are 0 outside RESP.

## Timing
- Request sampled in IDLE at cycle T:
  - `mem_en` at T+1.
  - `mem_rdata` valid at T+1+LAT.
  - done at T+2+LAT.
  - Next grant sampled at T+3+LAT.
- Misaligned: done and `err` at T+1; next grant sampled at T+2.
- Throughput: one access per LAT+3 cycles.
- Reset: every output is 0, state is IDLE, counter is 0, `last`=I.
- `rst` asserted in any state forces IDLE on the next edge.
  - The in-flight access is abandoned and no done is ever issued for it.
  - Late `mem_rdata` is ignored.

## Test plan
- After reset, `i_req` with `i_addr`=0x0010, model returns 0xA5A5 → `mem_en`=1, `mem_wr`=0, `mem_addr`=0x0010 at T+1; `i_done`=1, `i_rdata`=0xA5A5 at T+6 (LAT=4); `d_done` stays 0.
- `i_req` (0x0020) and `d_req` load (0x0100) both raised at T → D served first, `d_done` at T+6; I granted at T+7, `mem_addr`=0x0020 at T+8, `i_done` at T+13.
- `d_req` store, `d_addr`=0x0040, `d_wdata`=0x1234 → `mem_en`=1, `mem_wr`=1, `mem_wdata`=0x1234 at T+1; `d_done`=1, `d_rdata`=0 at T+6; `err`=0.
- `d_req` load, `d_addr`=0x0041 → `mem_en` never asserted; `d_done`=1, `err`=1, `d_rdata`=0 at T+1; `err` low in all other cycles.
- `rst` raised for one cycle at T+3 during a fetch → from T+4 all outputs 0, no `i_done` for that fetch; a fresh fetch issued afterwards completes with LAT+2 latency.
- `i_req` and `d_req` held high for 4 grants with fresh addresses → grant order D, I, D, I; done pulses spaced 7 cycles apart.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port, fixed-latency memory between the
// fetch (I) and load/store (D) ports; misaligned word accesses complete at once with err.
module mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int LAT    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_done,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              err,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
   typedef enum logic {P_I, P_D} port_t;

   state_t            r_state, w_next_state;
   logic [CNT_W-1:0]  r_cnt;
   port_t             r_port, r_last, w_grant_port;
   logic [ADDR_W-1:0] r_addr, w_grant_addr;
   logic              r_wr, r_err;
   logic [DATA_W-1:0] r_wdata, r_rdata;
   logic              w_grant, w_cnt_zero, w_issue, w_resp, w_rd_ok;

   // On contention the port that was not served last wins.
   always_comb begin
      w_grant      = (r_state == S_IDLE) && (i_req || d_req);
      w_grant_port = (d_req && (!i_req || r_last == P_I)) ? P_D : P_I;
      w_grant_addr = (w_grant_port == P_D) ? d_addr : i_addr;
      w_cnt_zero   = (r_cnt == '0);
   end

   always_comb begin
      // NOTE: default first, so every path assigns w_next_state and no latch is inferred.
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE:  if (w_grant) w_next_state = w_grant_addr[0] ? S_RESP : S_ISSUE;
         S_ISSUE: w_next_state = S_WAIT;
         S_WAIT:  if (w_cnt_zero) w_next_state = S_RESP;
         S_RESP:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_port  <= P_I;
         r_last  <= P_I;
         r_addr  <= '0;
         r_wr    <= 1'b0;
         r_err   <= 1'b0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_grant) begin
            r_port  <= w_grant_port;
            r_last  <= w_grant_port;
            r_addr  <= w_grant_addr;
            r_wr    <= (w_grant_port == P_D) && d_wr;
            r_wdata <= (w_grant_port == P_D) ? d_wdata : '0;
            r_err   <= w_grant_addr[0];
         end
         case (r_state)
            S_ISSUE: r_cnt <= CNT_W'(LAT - 1);
            S_WAIT: begin
               if (w_cnt_zero) r_rdata <= mem_rdata;
               else            r_cnt   <= r_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Outputs decode registered state only; request inputs never reach the memory side.
   always_comb begin
      w_issue   = (r_state == S_ISSUE);
      w_resp    = (r_state == S_RESP);
      w_rd_ok   = !r_wr && !r_err;
      mem_en    = w_issue;
      mem_wr    = w_issue && r_wr;
      mem_addr  = w_issue ? r_addr : '0;
      mem_wdata = w_issue ? r_wdata : '0;
      i_done    = w_resp && (r_port == P_I);
      d_done    = w_resp && (r_port == P_D);
      err       = w_resp && r_err;
      i_rdata   = (i_done && w_rd_ok) ? r_rdata : '0;
      d_rdata   = (d_done && w_rd_ok) ? r_rdata : '0;
   end

endmodule
